reg_bank_write_arbiter: RTL and testbench
=========================================

# reg_bank_write_arbiter

Round-robin write scheduler for the bank of 12-bit enable-loaded storage registers in the datapath. Three requesters, such as the user-input decoder, the time-keeping update logic and the configuration loader, compete for write access. The block serialises their requests, drives one register's load enable for exactly one cycle, and returns a completion pulse to the winning requester. No two writes ever reach the bank in the same cycle.

## Interface
- DATA_W, 12, width of each storage register and of the write data
- NUM_REGS, 8, number of registers in the bank (1..2^ADDR_W)
- ADDR_W, 3, register address width
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- req  in  3  per-requester write request, level; bit i = requester i
- addr_flat  in  3*ADDR_W  target addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
- data_flat  in  3*DATA_W  write data; requester i uses bits [i*DATA_W +: DATA_W]
- gnt  out  3  one-hot grant, high during WRITE and DONE for the winner
- done  out  3  one-cycle completion pulse to the winner
- err  out  1  one-cycle pulse, coincident with done, when the latched address is >= NUM_REGS
- busy  out  1  high in any state other than IDLE
- reg_en  out  NUM_REGS  one-hot load enable to the register bank
- reg_data  out  DATA_W  data bus to the register bank

## Operation
- Three-state FSM: IDLE, WRITE, DONE.
- IDLE:
  - If req != 0, select the winner by round-robin. Search starts at pointer ptr and wraps 2 -> 0.
  - Latch the winner index, its addr and its data into holding registers.
  - Set gnt to the winner and go to WRITE.
  - If req == 0, stay in IDLE.
- WRITE:
  - reg_en[latched addr] = 1 for exactly one cycle; reg_data = latched data.
  - If the latched addr >= NUM_REGS, reg_en stays 0.
  - Go to DONE unconditionally.
- DONE:
  - done[winner] = 1 for one cycle; err = 1 if the address was out of range.
  - ptr <= (winner + 1) mod 3. Clear gnt at exit and go to IDLE.
- Handshake:
  - A requester holds req, addr and data stable until its done pulse.
  - addr and data are sampled only in IDLE on the granting edge; later changes do not affect the transaction in progress.
  - req still high after done counts as a new request. It competes under the rotated pointer, so the requester cannot starve the others.
- reg_data holds the last latched value between transactions. reg_en is 0 in IDLE and DONE.
- Simultaneous requests: exactly one is granted; the others wait, and their req must stay high.
- A req that drops before grant is simply not served; no error is raised.
- Reset:
  - Values: state IDLE, ptr 0, gnt 0, done 0, err 0, busy 0, reg_en 0, reg_data 0, holding registers 0.
  - Asserted mid-transaction, it aborts immediately. reg_en falls asynchronously and no done is issued.

## Timing
- Request sampled high at edge k (IDLE):
  - gnt and busy high after edge k.
  - reg_en high from edge k to edge k+1; the target register loads at edge k+1.
  - done pulse from edge k+1 to edge k+2; IDLE again after edge k+2.
- Request-to-load latency: 1 cycle. Request-to-done: 2 cycles. Throughput: one write per 3 cycles.
- All outputs are registered or decoded from state only; there is no combinational path from req, addr_flat or data_flat to any output.

## Test plan
- After reset, all outputs are 0.
  - req=001, addr0=5, data0=12'hABC -> reg_en=8'b0010_0000 and reg_data=12'hABC for 1 cycle.
  - Then done=001 for 1 cycle; busy high for 2 cycles.
- req=111 held continuously, with ptr=0 after reset.
  - Grant order 0,1,2,0, each 3 cycles apart.
  - Exactly one reg_en bit high per WRITE cycle and never two.
- With NUM_REGS=6, req=010, addr1=7 -> reg_en stays 0; done=010 and err=1 in the same cycle.
- Requester 2 changes data2 from 12'h111 to 12'h222 one cycle after grant -> reg_data=12'h111 during WRITE.
- Reset pulsed during WRITE -> reg_en, gnt and busy fall immediately, and no done pulse follows.
  - After release with req=100, a normal transaction completes in 2 cycles with ptr starting at 0.
- After requester 0 completes, req=101 -> requester 2 is granted before requester 0.

Source files
------------

// File: rtl/reg_bank_write_arbiter_if.sv
// rtl/reg_bank_write_arbiter_if.sv - requester and register-bank signals of the write arbiter
//
// Purpose: bundles the three-requester write bus and the register-bank load
//          port so the arbiter and its users share one connection.
// Signals:
//   req        3                 per-requester write request, level
//   addr_flat  3*ADDR_W          requester i address at [i*ADDR_W +: ADDR_W]
//   data_flat  3*DATA_W          requester i data at [i*DATA_W +: DATA_W]
//   gnt        3                 one-hot grant, held through WRITE and DONE
//   done       3                 one-cycle completion pulse to the winner
//   err        1                 one-cycle pulse with done for an out-of-range address
//   busy       1                 arbiter is not idle
//   reg_en     NUM_REGS          one-hot register load enable
//   reg_data   DATA_W            register write data
// Modports:
//   master  requester side (drives req/addr/data, observes the rest)
//   slave   arbiter side

interface reg_bank_write_arbiter_if #(
    parameter int DATA_W   = 12,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
);
    logic [2:0]          req;
    logic [3*ADDR_W-1:0] addr_flat;
    logic [3*DATA_W-1:0] data_flat;
    logic [2:0]          gnt;
    logic [2:0]          done;
    logic                err;
    logic                busy;
    logic [NUM_REGS-1:0] reg_en;
    logic [DATA_W-1:0]   reg_data;

    modport master (
        output req,
        output addr_flat,
        output data_flat,
        input  gnt,
        input  done,
        input  err,
        input  busy,
        input  reg_en,
        input  reg_data
    );

    modport slave (
        input  req,
        input  addr_flat,
        input  data_flat,
        output gnt,
        output done,
        output err,
        output busy,
        output reg_en,
        output reg_data
    );
endinterface

// File: rtl/reg_bank_write_arbiter.sv
// rtl/reg_bank_write_arbiter.sv - round-robin write scheduler for a bank of load-enabled registers
//
// Purpose: serialises write requests from three requesters onto a bank of
//          NUM_REGS registers of DATA_W bits. One transaction takes three
//          cycles (IDLE grant, WRITE load, DONE completion), so at most one
//          register load enable is ever asserted.
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous, active-high
//   bus    slave modport of reg_bank_write_arbiter_if
//          (req/addr_flat/data_flat in; gnt/done/err/busy/reg_en/reg_data out)
// Outputs are either registered or decoded from registered state only; no
// combinational path exists from req/addr_flat/data_flat to any output.

module reg_bank_write_arbiter #(
    parameter int DATA_W   = 12,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    reg_bank_write_arbiter_if.slave bus
);

    localparam int NUM_REQ = 3;

    // Register count widened by one bit so the range compare also works when
    // NUM_REGS == 2**ADDR_W.
    localparam logic [ADDR_W:0] NUM_REGS_EXT = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          ptr_q,   ptr_d;
    logic [1:0]          win_q,   win_d;
    logic [2:0]          gnt_q,   gnt_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   data_q,  data_d;

    logic                grant_found;
    logic [1:0]          grant_idx;
    logic [ADDR_W-1:0]   addr_sel;
    logic [DATA_W-1:0]   data_sel;
    logic                addr_in_range;
    logic [NUM_REGS-1:0] reg_en_c;

    // ------------------------------------------------------------------
    // Round-robin search: visit requesters ptr, ptr+1, ptr+2 (mod 3) and take
    // the first one with req high. Only meaningful in IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        logic [2:0] sum;
        logic [1:0] cand;
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        sum         = 3'd0;
        cand        = 2'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_q} + 3'(k);
            if (sum >= 3'(NUM_REQ)) begin
                sum = sum - 3'(NUM_REQ);
            end
            cand = sum[1:0];
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_found && cand == 2'(i) && bus.req[i]) begin
                    grant_found = 1'b1;
                    grant_idx   = 2'(i);
                end
            end
        end
    end

    // Address/data of the selected requester, picked out of the flat buses.
    always_comb begin
        addr_sel = '0;
        data_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == 2'(i)) begin
                addr_sel = bus.addr_flat[i*ADDR_W +: ADDR_W];
                data_sel = bus.data_flat[i*DATA_W +: DATA_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // State and holding registers. The asynchronous reset aborts a
    // transaction in flight: state returns to IDLE, so the decoded reg_en
    // and done drop at once and no completion is reported.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            win_q   <= 2'd0;
            gnt_q   <= 3'd0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. addr/data are captured only on the granting edge;
    // the requester may change them afterwards without effect.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        data_d  = data_q;

        unique case (state_q)
            IDLE: begin
                if (grant_found) begin
                    state_d = WRITE;
                    win_d   = grant_idx;
                    gnt_d   = 3'b001 << grant_idx;
                    addr_d  = addr_sel;
                    data_d  = data_sel;
                end
            end

            WRITE: begin
                state_d = DONE;
            end

            DONE: begin
                // Rotating past the winner keeps a requester that holds req
                // high from locking the others out.
                state_d = IDLE;
                gnt_d   = 3'd0;
                ptr_d   = (win_q == 2'd2) ? 2'd0 : win_q + 2'd1;
            end

            default: begin
                state_d = IDLE;
                gnt_d   = 3'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from registered state.
    // ------------------------------------------------------------------
    assign addr_in_range = ({1'b0, addr_q} < NUM_REGS_EXT);

    // An out-of-range address matches no register, so the bank sees no load.
    always_comb begin
        reg_en_c = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            reg_en_c[r] = (state_q == WRITE) && (addr_q == ADDR_W'(r));
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.done     = gnt_q & {3{state_q == DONE}};
    assign bus.err      = (state_q == DONE) && !addr_in_range;
    assign bus.busy     = (state_q != IDLE);
    assign bus.reg_en   = reg_en_c;
    assign bus.reg_data = data_q;

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// tb/tb_reg_bank_write_arbiter.sv - scoreboard bench for reg_bank_write_arbiter

module tb_reg_bank_write_arbiter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    reg_bank_write_arbiter_if #(.DATA_W(12), .NUM_REGS(8), .ADDR_W(3)) bif ();
    reg_bank_write_arbiter_if #(.DATA_W(12), .NUM_REGS(6), .ADDR_W(3)) bif6 ();

    reg_bank_write_arbiter #(.DATA_W(12), .NUM_REGS(8), .ADDR_W(3)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    reg_bank_write_arbiter #(.DATA_W(12), .NUM_REGS(6), .ADDR_W(3)) u_dut6 (
        .clk   (clk),
        .reset (reset),
        .bus   (bif6)
    );

    typedef struct {
        logic [2:0]  done;
        logic        err;
        logic [7:0]  reg_en;
        logic [11:0] reg_data;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [2:0] d, input logic [7:0] en, input logic [11:0] data);
        exp_t e;
        e.done     = d;
        e.err      = 1'b0;
        e.reg_en   = en;
        e.reg_data = data;
        sb_q.push_back(e);
    endtask

    task automatic set_req(input int i, input logic [2:0] a, input logic [11:0] d);
        bif.addr_flat[i*3 +: 3]   = a;
        bif.data_flat[i*12 +: 12] = d;
    endtask

    // Waits for n done pulses; each requester drops its req on its own done.
    task automatic run_txns(input int n, input string name);
        int seen;
        seen = 0;
        for (int c = 0; c < 40 && seen < n; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (bif.done[i]) begin
                    bif.req[i] = 1'b0;
                    seen++;
                end
            end
        end
        check(name, seen, n);
    endtask

    task automatic wait_gnt(input string name);
        int got;
        got = 0;
        for (int c = 0; c < 20 && got == 0; c++) begin
            @(negedge clk);
            if (bif.gnt != 3'd0) got = 1;
        end
        check(name, got, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Monitor: watches the WRITE cycle preceding each done pulse and
    // compares the completed transaction with the scoreboard head.
    // ------------------------------------------------------------------
    initial begin
        logic [7:0]  prev_en;
        logic [11:0] prev_data;
        int          busy_cnt;
        exp_t        e;
        prev_en   = '0;
        prev_data = '0;
        busy_cnt  = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_en  = '0;
                busy_cnt = 0;
            end else begin
                if (bif.busy) busy_cnt++;
                else          busy_cnt = 0;
                if (bif.reg_en != 8'd0) begin
                    check("reg_en_onehot", 32'($onehot(bif.reg_en)), 1);
                end
                if (bif.done != 3'd0) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_done", bif.done, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check("done_vec", bif.done, e.done);
                        check("err", bif.err, e.err);
                        check("write_reg_en", prev_en, e.reg_en);
                        check("write_reg_data", prev_data, e.reg_data);
                        check("busy_cycles", busy_cnt, 2);
                        check("reg_en_in_done", bif.reg_en, 0);
                        check("gnt_in_done", bif.gnt, e.done);
                    end
                end
                prev_en   = bif.reg_en;
                prev_data = bif.reg_data;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [2:0] prev_g;
        logic [2:0] gnt_order [4];
        int         gcount;
        int         last;
        int         lat;
        int         got;
        int         en_seen;

        gnt_order[0] = 3'b001;
        gnt_order[1] = 3'b010;
        gnt_order[2] = 3'b100;
        gnt_order[3] = 3'b001;

        reset          = 1'b1;
        bif.req        = 3'd0;
        bif.addr_flat  = '0;
        bif.data_flat  = '0;
        bif6.req       = 3'd0;
        bif6.addr_flat = '0;
        bif6.data_flat = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_gnt", bif.gnt, 0);
        check("rst_done", bif.done, 0);
        check("rst_err", bif.err, 0);
        check("rst_busy", bif.busy, 0);
        check("rst_reg_en", bif.reg_en, 0);
        check("rst_reg_data", bif.reg_data, 0);
        check("rst6_busy", bif6.busy, 0);

        // Single write: requester 0 to register 5
        set_req(0, 3'd5, 12'hABC);
        push_exp(3'b001, 8'b0010_0000, 12'hABC);
        bif.req = 3'b001;
        run_txns(1, "single_txn");

        // All three held high from ptr=0: order 0,1,2,0, three cycles apart
        do_reset();
        set_req(0, 3'd0, 12'h100);
        set_req(1, 3'd1, 12'h201);
        set_req(2, 3'd2, 12'h302);
        push_exp(3'b001, 8'h01, 12'h100);
        push_exp(3'b010, 8'h02, 12'h201);
        push_exp(3'b100, 8'h04, 12'h302);
        push_exp(3'b001, 8'h01, 12'h100);
        bif.req = 3'b111;
        gcount  = 0;
        last    = 0;
        prev_g  = 3'd0;
        for (int c = 0; c < 60 && gcount < 4; c++) begin
            @(negedge clk);
            if (bif.gnt != 3'd0 && prev_g == 3'd0) begin
                check("rr_gnt_order", bif.gnt, gnt_order[gcount]);
                if (gcount > 0) check("rr_spacing", c - last, 3);
                last = c;
                gcount++;
                if (gcount == 4) bif.req = 3'd0;
            end
            prev_g = bif.gnt;
        end
        check("rr_grant_count", gcount, 4);
        for (int c = 0; c < 10 && bif.busy; c++) @(negedge clk);
        check("rr_idle", bif.busy, 0);

        // Data changed after the grant does not reach the bank (ptr=1 now)
        set_req(2, 3'd4, 12'h111);
        push_exp(3'b100, 8'h10, 12'h111);
        bif.req = 3'b100;
        wait_gnt("chg_gnt");
        set_req(2, 3'd4, 12'h222);
        run_txns(1, "chg_txn");
        @(negedge clk);
        check("reg_data_hold", bif.reg_data, 12'h111);

        // Reset during WRITE aborts without a done
        set_req(0, 3'd3, 12'h5A5);
        bif.req = 3'b001;
        wait_gnt("abort_gnt");
        #2 reset = 1'b1;
        #1;
        check("abort_reg_en", bif.reg_en, 0);
        check("abort_gnt_clr", bif.gnt, 0);
        check("abort_busy", bif.busy, 0);
        bif.req = 3'd0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_no_done", bif.done, 0);
        check("abort_sb_empty", sb_q.size(), 0);

        // Normal transaction after reset: done two cycles after request
        set_req(2, 3'd1, 12'h0F0);
        push_exp(3'b100, 8'h02, 12'h0F0);
        bif.req = 3'b100;
        lat = 0;
        got = 0;
        for (int c = 1; c <= 10 && got == 0; c++) begin
            @(negedge clk);
            if (bif.done != 3'd0) begin
                lat = c;
                got = 1;
                bif.req = 3'd0;
            end
        end
        check("req_to_done", lat, 2);

        // Requester 0 done, then 101: requester 2 goes first
        set_req(0, 3'd6, 12'h066);
        push_exp(3'b001, 8'h40, 12'h066);
        bif.req = 3'b001;
        run_txns(1, "rot_first");
        set_req(0, 3'd7, 12'h077);
        set_req(2, 3'd0, 12'h200);
        push_exp(3'b100, 8'h01, 12'h200);
        push_exp(3'b001, 8'h80, 12'h077);
        bif.req = 3'b101;
        run_txns(2, "rot_pair");
        @(negedge clk);
        check("sb_drained", sb_q.size(), 0);

        // Six-register bank: address 7 is out of range
        bif6.addr_flat[3 +: 3]  = 3'd7;
        bif6.data_flat[12 +: 12] = 12'h777;
        bif6.req = 3'b010;
        en_seen = 0;
        got     = 0;
        for (int c = 0; c < 10 && got == 0; c++) begin
            @(negedge clk);
            if (bif6.reg_en != 6'd0) en_seen++;
            if (bif6.done != 3'd0) begin
                got = 1;
                check("oor_done", bif6.done, 3'b010);
                check("oor_err", bif6.err, 1);
                bif6.req = 3'd0;
            end
        end
        check("oor_done_seen", got, 1);
        check("oor_no_reg_en", en_seen, 0);
        @(negedge clk);
        check("oor_err_pulse", bif6.err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
